// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared types and constants for the multicycle MIPS main control
//            FSM: state encodings, opcodes, ALU-op and mux-select codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_if.sv
// ============================================================================
// Module   : mips_multicycle_ctrl_if
// Purpose  : Control bundle between the main control FSM (master) and the
//            multicycle datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic               zero;
    logic               mem_ready;

    logic               pc_en;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         Alu_op;
    logic [1:0]         PCSource;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, Alu_op, PCSource, illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, Alu_op, PCSource, illegal_op, state
    );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Main control FSM for the multicycle MIPS datapath. Sequences
//            fetch/decode/execute/memory/write-back, drives all datapath
//            enables and selects, and stalls on the memory-ready handshake.
// Options  : MCTRL_ADDI_EN - when defined, adds ADDI_EX/ADDI_WB and makes
//            opcode 001000 legal; otherwise addi is an illegal opcode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    mips_multicycle_ctrl_if.master bus
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_illegal;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;

    // State register: synchronous reset returns to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic, including opcode dispatch and illegal-opcode detect.
    always_comb begin
        w_next_state = S_FETCH;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH:     w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
                    OP_RTYPE:     w_next_state = S_EXEC_R;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
`ifdef MCTRL_ADDI_EN
                    OP_ADDI:      w_next_state = S_ADDI_EX;
`endif
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  w_next_state = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next_state = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next_state = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    w_next_state = S_R_WB;
`ifdef MCTRL_ADDI_EN
            S_ADDI_EX:   w_next_state = S_ADDI_WB;
`endif
            default:     w_next_state = S_FETCH;
        endcase
    end

    // Output decode from the current state; everything forced low in reset
    // so an aborted instruction cannot leave a partial register write.
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = SRCB_RT;
        w_alu_op        = ALUOP_ADD;
        w_pc_source     = PCSRC_ALU;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
            end
            S_DECODE:    w_alu_src_b = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            S_MEM_WB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            S_EXEC_R: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = ALUOP_SUB;
                w_pc_write_cond = 1'b1;
                w_pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = PCSRC_JUMP;
            end
`ifdef MCTRL_ADDI_EN
            S_ADDI_EX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB:   w_reg_write = 1'b1;
`endif
            default: ;
        endcase
        if (reset) begin
            w_pc_write      = 1'b0;
            w_pc_write_cond = 1'b0;
            w_iord          = 1'b0;
            w_mem_read      = 1'b0;
            w_mem_write     = 1'b0;
            w_ir_write      = 1'b0;
            w_mem_to_reg    = 1'b0;
            w_reg_dst       = 1'b0;
            w_reg_write     = 1'b0;
            w_alu_src_a     = 1'b0;
            w_alu_src_b     = 2'b00;
            w_alu_op        = 2'b00;
            w_pc_source     = 2'b00;
        end
    end

    assign bus.pc_en      = w_pc_write | (w_pc_write_cond & bus.zero);
    assign bus.IorD       = w_iord;
    assign bus.MemRead    = w_mem_read;
    assign bus.MemWrite   = w_mem_write;
    assign bus.IRWrite    = w_ir_write;
    assign bus.MemtoReg   = w_mem_to_reg;
    assign bus.RegDst     = w_reg_dst;
    assign bus.RegWrite   = w_reg_write;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.Alu_op     = w_alu_op;
    assign bus.PCSource   = w_pc_source;
    assign bus.illegal_op = w_illegal & ~reset;
    assign bus.state      = reset ? '0 : STATE_W'(r_state);

endmodule

`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath enable and mux select. It is the producer of the 2-bit `Alu_op` code that the ALU control decoder combines with `funct` to select the ALU operation. It also stalls on a memory-ready handshake.

## Interface
Parameters:
- `STATE_W`, 4: width of the exported state register.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  instruction bits [31:26] from the instruction register; stable after FETCH completes.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_en`  out  1  PC load enable = PCWrite | (PCWriteCond & `zero`).
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`  out  1  memory strobes.
- `IRWrite`  out  1  instruction register load.
- `MemtoReg`  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- `RegDst`  out  1  destination: 0 = rt, 1 = rd.
- `RegWrite`  out  1  register file write.
- `ALUSrcA`  out  1  0 = PC, 1 = rs.
- `ALUSrcB`  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- `Alu_op`  out  2  00 = add, 01 = subtract, 10 = decode `funct`.
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `state`  out  `STATE_W`  current state, for debug.

## Operation
Moore FSM. Outputs are decoded from the state register only, except `pc_en` (uses `zero`) and the `mem_ready` qualifications listed below. Any output not listed for a state is 0.

- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, Alu_op=00, PCSource=00, IRWrite=pc_en=`mem_ready`. Holds until `mem_ready`, then goes to DECODE.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, Alu_op=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw): MEM_ADDR
  - 000000: EXEC_R
  - 000100 (beq): BRANCH
  - 000010 (j): JUMP
  - 001000 (addi): ADDI_EX, only when configured in
  - otherwise: FETCH, with `illegal_op`=1 for this cycle.
- MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, Alu_op=00. Goes to MEM_READ for lw, otherwise MEM_WRITE.
- MEM_READ (3): MemRead=1, IorD=1. Holds until `mem_ready`, then MEM_WB.
- MEM_WB (4): RegDst=0, MemtoReg=1, RegWrite=1. Then FETCH.
- MEM_WRITE (5): MemWrite=1, IorD=1. Holds until `mem_ready`, then FETCH.
- EXEC_R (6): ALUSrcA=1, ALUSrcB=00, Alu_op=10. Then R_WB.
- R_WB (7): RegDst=1, MemtoReg=0, RegWrite=1. Then FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, Alu_op=01, PCWriteCond=1, PCSource=01. Then FETCH.
- JUMP (9): PCWrite=1, PCSource=10. Then FETCH.
- ADDI_EX (10): ALUSrcA=1, ALUSrcB=10, Alu_op=00. Then ADDI_WB.
- ADDI_WB (11): RegDst=0, MemtoReg=0, RegWrite=1. Then FETCH.
- Unused encodings (12-15): all outputs 0; next state FETCH.

## Timing
- While `reset`=1, all outputs are forced to 0 (`state` reads 0). The first cycle after release is FETCH.
- `reset` asserted mid-instruction aborts it: FETCH on the next edge, and no partial register write.
- Cycles per instruction with `mem_ready` tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle `mem_ready` is low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. The strobes stay asserted throughout the stall.
- `mem_ready` is ignored in every other state.
- `IRWrite` is never asserted outside the completing FETCH cycle.

## Configuration
- `MCTRL_ADDI_EN` defined: ADDI_EX and ADDI_WB exist, and opcode 001000 is legal.
- Not defined: those states are absent, and 001000 takes the illegal-opcode path (`illegal_op` pulse, return to FETCH).

## Structure
- Package `mips_pkg` holds:
  - the state enum (`STATE_W` bits, encodings as numbered above);
  - opcode constants;
  - `Alu_op` constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - `ALUSrcB` and `PCSource` select constants.
- No sub-module: one module containing a sequential state register, combinational next-state logic and combinational output decode.

## Test plan
- Reset held 3 cycles, then released, `mem_ready`=1: outputs all 0 during reset; first post-reset cycle is state 0 with MemRead=1, IRWrite=1, pc_en=1.
- lw (100011), `mem_ready`=1: states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in the 5th cycle. Repeat with `mem_ready` low 2 cycles in MEM_READ: 7 cycles total.
- R-type (000000): Alu_op=10 exactly in state 6, RegDst=1 and RegWrite=1 in state 7. Sequence sw (101011): MemWrite=1 only in state 5.
- beq (000100): `zero`=1 gives pc_en=1 with PCSource=01 and Alu_op=01 in state 8. `zero`=0 gives pc_en=0 in that cycle.
- Opcode 111111: `illegal_op`=1 for one cycle in DECODE, then FETCH. Opcode 001000: ADDI_WB RegWrite=1 with `MCTRL_ADDI_EN` defined; illegal path without it.
- `reset` asserted in state 3 with `mem_ready`=0: next state FETCH, with RegWrite never asserted.
